// File: rtl/btn_pkg.sv
// Shared definitions for the push-button input stage: button indices,
// direction encodings and the direction arbiter state type.
package btn_pkg;

   localparam int unsigned BTN_CENTRE = 0;
   localparam int unsigned BTN_UP     = 1;
   localparam int unsigned BTN_LEFT   = 2;
   localparam int unsigned BTN_RIGHT  = 3;
   localparam int unsigned BTN_DOWN   = 4;

   localparam logic [3:0] DIR_NONE  = 4'b0000;
   localparam logic [3:0] DIR_UP    = 4'b0001;
   localparam logic [3:0] DIR_LEFT  = 4'b0010;
   localparam logic [3:0] DIR_RIGHT = 4'b0100;
   localparam logic [3:0] DIR_DOWN  = 4'b1000;

   typedef enum logic {
      IDLE,
      LOCKED
   } arb_state_e;

   // Direction bits are ordered by priority, so isolating the lowest set bit
   // yields up > left > right > down.
   function automatic logic [3:0] pick_dir(input logic [3:0] held);
      pick_dir = held & (~held + 4'd1);
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button: 2-flop synchroniser, stability counter, debounced level and
// a one-cycle pulse on each accepted rising edge.
module debounce_cell #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_clean,
   output logic btn_press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync_q1;
   logic             sync_q2;
   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst) begin
         sync_q1   <= 1'b0;
         sync_q2   <= 1'b0;
         cnt       <= '0;
         btn_clean <= 1'b0;
         btn_press <= 1'b0;
      end else begin
         sync_q1   <= btn_raw;
         sync_q2   <= sync_q1;
         btn_press <= 1'b0;
         if (sync_q2 == btn_clean) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            // Accept the new level; the pulse rises on the same edge as btn_clean.
            btn_clean <= sync_q2;
            btn_press <= sync_q2;
            cnt       <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Maze game input stage: debounces the board buttons and arbitrates the four
// direction buttons into a strictly one-hot direction vector.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned NUM_BTN         = 5,
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [NUM_BTN-1:0] btn_raw,
   output logic [NUM_BTN-1:0] btn_clean,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [3:0]         dir_onehot,
   output logic               restart_req,
   output logic               dir_valid
);

   arb_state_e state;
   arb_state_e state_nxt;
   logic [3:0] dir_sel;
   logic [3:0] dir_sel_nxt;
   logic [3:0] dir_held;

   for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_cell
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
      ) u_cell (
         .clk       (clk),
         .rst       (rst),
         .btn_raw   (btn_raw[gi]),
         .btn_clean (btn_clean[gi]),
         .btn_press (btn_press[gi])
      );
   end

   assign dir_held    = btn_clean[BTN_DOWN:BTN_UP];
   assign restart_req = btn_clean[BTN_CENTRE];

   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= IDLE;
         dir_sel <= DIR_NONE;
      end else begin
         state   <= state_nxt;
         dir_sel <= dir_sel_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      dir_sel_nxt = dir_sel;
      case (state)
         IDLE: begin
            if (|dir_held) begin
               state_nxt   = LOCKED;
               dir_sel_nxt = pick_dir(dir_held);
            end
         end
         LOCKED: begin
            // Only the locked direction's release matters; passing through
            // IDLE guarantees at least one all-zero cycle before a new winner.
            if ((dir_held & dir_sel) == DIR_NONE) begin
               state_nxt   = IDLE;
               dir_sel_nxt = DIR_NONE;
            end
         end
         default: begin
            state_nxt   = IDLE;
            dir_sel_nxt = DIR_NONE;
         end
      endcase
   end

   always_comb begin
      dir_onehot = DIR_NONE;
      if (state == LOCKED) begin
         dir_onehot = dir_sel;
      end
      dir_valid = |dir_onehot;
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner with a short debounce window; a
// behavioural model predicts every output each cycle.
module tb_btn_conditioner;

   localparam int unsigned DEB = 4;

   typedef struct packed {
      logic [4:0] clean;
      logic [4:0] press;
      logic [3:0] dir;
      logic       restart;
      logic       valid;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [4:0] btn_raw = '0;
   logic [4:0] btn_clean;
   logic [4:0] btn_press;
   logic [3:0] dir_onehot;
   logic       restart_req;
   logic       dir_valid;

   int   n_cmp = 0;
   int   n_err = 0;
   int   press_cnt [5];
   exp_t sb [$];
   exp_t e;

   // Model state
   logic [4:0]     m_s1 = '0, m_s2 = '0, m_clean = '0, m_press = '0;
   logic [DEB-1:0] m_hist [5];
   int             m_n [5];
   int             m_dir_idx = 0;

   btn_conditioner #(
      .NUM_BTN         (5),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (3)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .btn_raw     (btn_raw),
      .btn_clean   (btn_clean),
      .btn_press   (btn_press),
      .dir_onehot  (dir_onehot),
      .restart_req (restart_req),
      .dir_valid   (dir_valid)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Predict outputs after the coming clock edge from raw/rst driven now.
   task automatic model_step(input logic [4:0] raw, input logic rst_v);
      exp_t x;
      logic [DEB-1:0] want;
      if (!rst_v) begin
         m_s1 = '0; m_s2 = '0; m_clean = '0; m_press = '0; m_dir_idx = 0;
         for (int i = 0; i < 5; i++) begin m_n[i] = 0; m_hist[i] = '0; end
      end else begin
         if (m_dir_idx == 0) begin
            if (m_clean[1])      m_dir_idx = 1;
            else if (m_clean[2]) m_dir_idx = 2;
            else if (m_clean[3]) m_dir_idx = 3;
            else if (m_clean[4]) m_dir_idx = 4;
         end else if (!m_clean[m_dir_idx]) begin
            m_dir_idx = 0;
         end
         m_press = '0;
         for (int i = 0; i < 5; i++) begin
            m_hist[i] = {m_hist[i][DEB-2:0], m_s2[i]};
            if (m_n[i] < DEB) m_n[i]++;
            want = m_clean[i] ? '0 : '1;
            if (m_n[i] == DEB && m_hist[i] == want) begin
               m_clean[i] = ~m_clean[i];
               m_press[i] = m_clean[i];
               m_n[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = raw;
      end
      x.clean   = m_clean;
      x.press   = m_press;
      x.dir     = (m_dir_idx == 0) ? 4'b0000 : 4'(1 << (m_dir_idx - 1));
      x.restart = m_clean[0];
      x.valid   = (m_dir_idx != 0);
      sb.push_back(x);
   endtask

   // Drive one cycle; returns after the edge has been scoreboarded.
   task automatic tick(input logic [4:0] raw, input logic rst_v = 1'b1);
      @(negedge clk);
      btn_raw = raw;
      rst     = rst_v;
      model_step(raw, rst_v);
      @(posedge clk);
      #2;
   endtask

   task automatic ticks(input logic [4:0] raw, input int n);
      for (int k = 0; k < n; k++) tick(raw);
   endtask

   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check_val("clean",   32'(btn_clean),   32'(e.clean));
         check_val("press",   32'(btn_press),   32'(e.press));
         check_val("dir",     32'(dir_onehot),  32'(e.dir));
         check_val("restart", 32'(restart_req), 32'(e.restart));
         check_val("valid",   32'(dir_valid),   32'(e.valid));
         for (int i = 0; i < 5; i++) press_cnt[i] += int'(btn_press[i]);
      end
   end

   initial begin
      int p0;
      logic [4:0] r;
      for (int i = 0; i < 5; i++) press_cnt[i] = 0;

      tick(5'b00000, 1'b0);
      tick(5'b00000, 1'b0);
      check_val("reset_clean", 32'(btn_clean), 32'h0);
      check_val("reset_dir",   32'(dir_onehot), 32'h0);

      // Steady press on up: clean/press at edge 6, direction at edge 7
      for (int k = 1; k <= 7; k++) begin
         tick(5'b00010);
         if (k == 5) check_val("t1_clean5", 32'(btn_clean[1]), 32'h0);
         if (k == 6) begin
            check_val("t1_clean6", 32'(btn_clean[1]), 32'h1);
            check_val("t1_press6", 32'(btn_press[1]), 32'h1);
            check_val("t1_dir6",   32'(dir_onehot), 32'h0);
         end
         if (k == 7) begin
            check_val("t1_press7", 32'(btn_press[1]), 32'h0);
            check_val("t1_dir7",   32'(dir_onehot), 32'h1);
         end
      end
      ticks(5'b00010, 3);
      ticks(5'b00000, 10);
      check_val("t1_rel_dir", 32'(dir_onehot), 32'h0);

      // Short glitch on right is rejected
      p0 = press_cnt[3];
      ticks(5'b01000, 3);
      ticks(5'b00000, 10);
      check_val("t2_press_cnt", 32'(press_cnt[3] - p0), 32'h0);

      // Left and down together: left wins and holds when down is released
      ticks(5'b10100, 8);
      check_val("t3_dir", 32'(dir_onehot), 32'h2);
      ticks(5'b00100, 8);
      check_val("t3_dir_hold", 32'(dir_onehot), 32'h2);
      ticks(5'b00000, 10);

      // Down locked, up added, down released: 1000 -> 0000 -> 0001
      ticks(5'b10000, 8);
      check_val("t4_down", 32'(dir_onehot), 32'h8);
      ticks(5'b10010, 8);
      check_val("t4_still_down", 32'(dir_onehot), 32'h8);
      ticks(5'b00010, 6);
      check_val("t4_down6", 32'(dir_onehot), 32'h8);
      tick(5'b00010);
      check_val("t4_gap", 32'(dir_onehot), 32'h0);
      tick(5'b00010);
      check_val("t4_up", 32'(dir_onehot), 32'h1);
      ticks(5'b00000, 10);

      // Restart button
      ticks(5'b00001, 5);
      check_val("t5_restart5", 32'(restart_req), 32'h0);
      tick(5'b00001);
      check_val("t5_restart6", 32'(restart_req), 32'h1);
      check_val("t5_dir", 32'(dir_onehot), 32'h0);
      ticks(5'b00000, 8);

      // Reset mid-count on right discards the partial count
      ticks(5'b01000, 3);
      tick(5'b01000, 1'b0);
      check_val("t5_rst_clean", 32'(btn_clean), 32'h0);
      ticks(5'b01000, 5);
      check_val("t5_after5", 32'(btn_clean[3]), 32'h0);
      tick(5'b01000);
      check_val("t5_after6", 32'(btn_clean[3]), 32'h1);
      ticks(5'b00000, 10);

      // Chatter on up, then steady high: one pulse, 6 cycles after final rise
      p0 = press_cnt[1];
      for (int k = 0; k < 20; k++) tick((k % 2 == 0) ? 5'b00010 : 5'b00000);
      check_val("t6_no_press", 32'(press_cnt[1] - p0), 32'h0);
      for (int k = 1; k <= 8; k++) begin
         tick(5'b00010);
         if (k == 6) check_val("t6_press6", 32'(btn_press[1]), 32'h1);
      end
      check_val("t6_press_cnt", 32'(press_cnt[1] - p0), 32'h1);
      ticks(5'b00000, 10);

      // Random held patterns with occasional resets
      for (int k = 0; k < 60; k++) begin
         r = 5'($urandom_range(0, 31));
         for (int j = 0; j < int'($urandom_range(1, 9)); j++)
            tick(r, ($urandom_range(0, 49) != 0));
      end
      ticks(5'b00000, 12);

      check_val("sb_drain", 32'(sb.size()), 32'h0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
Upstream input stage for the maze game top level. It turns the five raw board push-buttons into clean game inputs:
- synchronised and debounced levels;
- one-cycle press pulses;
- a strictly one-hot direction vector, since the movement logic only acts on exactly one direction bit;
- a debounced restart request on button 0.

It runs in the 100 MHz system clock domain.

Parameters:
NUM_BTN, 5, number of push-buttons (bit 0 = centre/restart, 1 = up, 2 = left, 3 = right, 4 = down)
DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a level change (10 ms at 100 MHz); minimum 2
CNT_W, 20, debounce counter width; must satisfy 2^CNT_W >= DEBOUNCE_CYCLES

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-low reset
btn_raw  input  NUM_BTN  asynchronous raw button levels, active-high
btn_clean  output  NUM_BTN  debounced button levels
btn_press  output  NUM_BTN  one-cycle pulse on each debounced 0->1 transition
dir_onehot  output  4  arbitrated direction: 0001 up, 0010 left, 0100 right, 1000 down, 0000 none
restart_req  output  1  equals btn_clean[0]
dir_valid  output  1  high whenever dir_onehot is non-zero

Behaviour:
- Reset (rst==0 at a clk edge):
  - synchroniser flops, counters, btn_clean, btn_press, dir_onehot, dir_valid and restart_req all go to 0;
  - arbiter goes to IDLE;
  - reset applied mid-debounce discards the partial count; no pulse is emitted.
- Synchroniser: a 2-flop chain per bit, giving sync_i = btn_raw[i] delayed by 2 cycles.
- Debounce, per bit:
  - if sync_i == btn_clean[i], cnt_i <= 0;
  - else if cnt_i == DEBOUNCE_CYCLES-1: btn_clean[i] <= sync_i and cnt_i <= 0;
  - else cnt_i <= cnt_i + 1.
  - A glitch shorter than DEBOUNCE_CYCLES never changes btn_clean.
  - Latency from a steady btn_raw edge to btn_clean = DEBOUNCE_CYCLES + 2 cycles.
  - Release is debounced identically.
- btn_press[i] is registered and high for exactly the one cycle in which btn_clean[i] rises (same edge). A release produces no pulse.
- Direction arbiter FSM, inputs btn_clean[4:1], registered outputs (one cycle after btn_clean):
  - IDLE:
    - if any direction is held, go to LOCKED and latch the winner.
    - When several directions are held in the same cycle, priority is up > left > right > down.
    - dir_onehot = 0000 while in IDLE.
  - LOCKED(d):
    - dir_onehot = one-hot of d while btn_clean of d stays high; other directions pressed meanwhile are ignored.
    - When btn_clean of d falls, go to IDLE and set dir_onehot = 0000 for at least one cycle.
    - From IDLE, re-arbitrate among whatever is still held.
  - dir_onehot is never multi-hot.
- Restart:
  - restart_req follows btn_clean[0] combinationally from that register.
  - It does not affect the arbiter. The top level gives restart precedence over movement.
- Counter wrap: cannot occur; the counter clears on reaching DEBOUNCE_CYCLES-1.

Decomposition:
- Shared package btn_pkg holds:
  - button index constants: BTN_CENTRE=0, BTN_UP=1, BTN_LEFT=2, BTN_RIGHT=3, BTN_DOWN=4;
  - direction one-hot constants: DIR_NONE=4'b0000, DIR_UP=4'b0001, DIR_LEFT=4'b0010, DIR_RIGHT=4'b0100, DIR_DOWN=4'b1000;
  - arbiter state encoding (IDLE, LOCKED).
- Sub-module debounce_cell (synchroniser + counter + clean/press registers for one bit), parameterised by DEBOUNCE_CYCLES and CNT_W and generated NUM_BTN times.
- The arbiter FSM stays in btn_conditioner.

Test Plan (DEBOUNCE_CYCLES=4, CNT_W=3):
- Raw btn[1] rises and stays high -> btn_clean[1] and btn_press[1] rise at cycle 6 after the edge; btn_press is high for 1 cycle only; dir_onehot=0001 at cycle 7.
- btn[3] raw pulse 3 cycles wide, then low -> btn_clean, btn_press and dir_onehot stay 0 throughout.
- btn[2] and btn[4] rise in the same cycle -> dir_onehot=0010. btn[4] released while btn[2] is still held -> dir_onehot stays 0010.
- Hold btn[4] (dir 1000), then press btn[1], then release btn[4] -> dir_onehot 1000, then 0000 for one cycle, then 0001.
- btn[0] held -> restart_req=1 after 6 cycles with dir_onehot unaffected. rst low for 1 cycle mid-count on btn[3] -> all outputs 0; the count restarts from 0 after reset releases.
- Raw btn[1] chatters 1,0,1,0 every cycle for 20 cycles, then stays high -> single btn_press[1] pulse, 6 cycles after the final rising edge.
